// File: rtl/periph_demux_pkg.sv
// Shared constants and width helpers for the multi-outstanding peripheral demux.
package periph_demux_pkg;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADACCE5;

  // Destination ids cover every target plus one extra code for unmapped accesses.
  function automatic int unsigned id_width(input int unsigned nb_targets);
    return $clog2(nb_targets + 1);
  endfunction

  function automatic int unsigned unmapped_id(input int unsigned nb_targets);
    return nb_targets;
  endfunction

endpackage

// File: rtl/periph_demux_dest_fifo.sv
// In-order FIFO of destination ids for granted but not yet answered transactions.
module periph_demux_dest_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SLOTS = 1 << PTR_W;

  logic [WIDTH-1:0] mem [SLOTS];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap by compare-and-clear so non-power-of-2 depths work.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/periph_demux_multi.sv
// Routes one core peripheral port to NB_TARGETS targets with in-order multi-outstanding responses.
module periph_demux_multi
  import periph_demux_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned NB_TARGETS      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned PAGE_MSB        = 19,
  parameter int unsigned PAGE_LSB        = 14,
  parameter logic [PAGE_MSB-PAGE_LSB:0] PAGE_MATCH = 6'b000001,
  parameter int unsigned SEL_MSB         = 13,
  parameter int unsigned SEL_LSB         = 10,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(ERR_RDATA_DEFAULT)
) (
  input  logic                                  clk,
  input  logic                                  rst_i,
  input  logic                                  data_req_i,
  input  logic [ADDR_WIDTH-1:0]                 data_add_i,
  input  logic                                  data_wen_i,
  input  logic [DATA_WIDTH-1:0]                 data_wdata_i,
  input  logic [BE_WIDTH-1:0]                   data_be_i,
  output logic                                  data_gnt_o,
  output logic                                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0]                 data_r_rdata_o,
  output logic                                  data_r_opc_o,
  output logic [NB_TARGETS-1:0]                 tgt_req_o,
  output logic [NB_TARGETS-1:0][ADDR_WIDTH-1:0] tgt_add_o,
  output logic [NB_TARGETS-1:0]                 tgt_wen_o,
  output logic [NB_TARGETS-1:0][DATA_WIDTH-1:0] tgt_wdata_o,
  output logic [NB_TARGETS-1:0][BE_WIDTH-1:0]   tgt_be_o,
  input  logic [NB_TARGETS-1:0]                 tgt_gnt_i,
  input  logic [NB_TARGETS-1:0]                 tgt_r_valid_i,
  input  logic [NB_TARGETS-1:0][DATA_WIDTH-1:0] tgt_r_rdata_i,
  input  logic [NB_TARGETS-1:0]                 tgt_r_opc_i,
  output logic                                  spurious_resp_o
);

  localparam int unsigned ID_W  = id_width(NB_TARGETS);
  localparam int unsigned SEL_W = SEL_MSB - SEL_LSB + 1;
  localparam logic [ID_W-1:0] UNMAPPED = ID_W'(unmapped_id(NB_TARGETS));

  logic [SEL_W-1:0]      sel;
  logic                  mapped;
  logic [ID_W-1:0]       dest_id;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ID_W-1:0]       fifo_head;
  logic                  fifo_pop;
  logic [NB_TARGETS-1:0] head_hit;
  logic                  spurious_c;

  assign sel     = data_add_i[SEL_MSB:SEL_LSB];
  assign mapped  = (data_add_i[PAGE_MSB:PAGE_LSB] == PAGE_MATCH) && (32'(sel) < 32'(NB_TARGETS));
  assign dest_id = mapped ? ID_W'(sel) : UNMAPPED;

  // Core fields go to every target unregistered; only req is steered.
  always_comb begin
    for (int t = 0; t < NB_TARGETS; t++) begin
      tgt_add_o[t]   = data_add_i;
      tgt_wen_o[t]   = data_wen_i;
      tgt_wdata_o[t] = data_wdata_i;
      tgt_be_o[t]    = data_be_i;
    end
  end

  // A full FIFO blocks issue outright, keeping grant independent of responses.
  always_comb begin
    tgt_req_o  = '0;
    data_gnt_o = 1'b0;
    if (!fifo_full) begin
      if (mapped) begin
        for (int t = 0; t < NB_TARGETS; t++) begin
          if (dest_id == ID_W'(t)) begin
            tgt_req_o[t] = data_req_i;
            data_gnt_o   = tgt_gnt_i[t];
          end
        end
      end else begin
        data_gnt_o = data_req_i;
      end
    end
  end

  // Response comes only from the head target; unmapped heads answer immediately.
  always_comb begin
    data_r_valid_o = 1'b0;
    data_r_rdata_o = '0;
    data_r_opc_o   = 1'b0;
    fifo_pop       = 1'b0;
    head_hit       = '0;
    if (!fifo_empty) begin
      if (fifo_head == UNMAPPED) begin
        data_r_valid_o = 1'b1;
        data_r_rdata_o = ERR_RDATA;
        data_r_opc_o   = 1'b1;
        fifo_pop       = 1'b1;
      end else begin
        for (int t = 0; t < NB_TARGETS; t++) begin
          if (fifo_head == ID_W'(t)) begin
            head_hit[t]    = 1'b1;
            data_r_valid_o = tgt_r_valid_i[t];
            data_r_rdata_o = tgt_r_rdata_i[t];
            data_r_opc_o   = tgt_r_opc_i[t];
            fifo_pop       = tgt_r_valid_i[t];
          end
        end
      end
    end
  end

  assign spurious_c = |(tgt_r_valid_i & ~head_hit);

  always_ff @(posedge clk) begin
    if (rst_i) begin
      spurious_resp_o <= 1'b0;
    end else if (spurious_c) begin
      spurious_resp_o <= 1'b1;
    end
  end

  periph_demux_dest_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W)
  ) u_dest_fifo (
    .clk       (clk),
    .rst_i     (rst_i),
    .push      (data_req_i && data_gnt_o),
    .push_data (dest_id),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

endmodule
